ghost_mode_scheduler: RTL

Sequences the ghost behaviour mode for a level: alternating scatter/chase phases of fixed second-length, then permanent chase, with frightened mode on a power pellet. It owns a one-second prescaler off CLOCK_50 plus saturating second counters, and publishes the current mode to the ghost AI and sprite logic. One instance per game core, driven by the level-start and pellet-eaten events from game control.

---
 rtl/ghost_mode_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ghost_mode_scheduler.sv
// Ghost mode sequencer: timed scatter/chase rounds, then permanent chase,
// with pellet-triggered fright that resumes the interrupted phase.
module ghost_mode_scheduler #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned SCATTER_S = 7,
  parameter int unsigned CHASE_S   = 20,
  parameter int unsigned FRIGHT_S  = 6,
  parameter int unsigned WARN_S    = 2,
  parameter int unsigned ROUNDS    = 4
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           pellet,
  output logic [1:0]                     mode,
  output logic                           reverse,
  output logic                           fright_warn,
  output logic                           sec_tick,
  output logic [$clog2(ROUNDS+1)-1:0]    round_cnt
);

  localparam int unsigned PSW    = $clog2(TICK_DIV);
  localparam int unsigned PH_MAX = (SCATTER_S > CHASE_S) ? SCATTER_S : CHASE_S;
  localparam int unsigned PHW    = $clog2(PH_MAX + 1);
  localparam int unsigned FW     = $clog2(FRIGHT_S + 1);
  localparam int unsigned RW     = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SCATTER = 2'b01,
    CHASE   = 2'b10,
    FRIGHT  = 2'b11
  } mode_e;

  mode_e           state, state_n, saved_mode, saved_mode_n;
  logic [PSW-1:0]  presc, presc_n;
  logic [PHW-1:0]  phase, phase_n, saved_phase, saved_phase_n;
  logic [FW-1:0]   fcnt, fcnt_n;
  logic [RW-1:0]   round_n;
  logic            reverse_n, warn_n, run, tick, rev_req;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      saved_mode  <= IDLE;
      presc       <= '0;
      phase       <= '0;
      saved_phase <= '0;
      fcnt        <= '0;
      round_cnt   <= '0;
      reverse     <= 1'b0;
      fright_warn <= 1'b0;
      sec_tick    <= 1'b0;
    end else begin
      state       <= state_n;
      saved_mode  <= saved_mode_n;
      presc       <= presc_n;
      phase       <= phase_n;
      saved_phase <= saved_phase_n;
      fcnt        <= fcnt_n;
      round_cnt   <= round_n;
      reverse     <= reverse_n;
      fright_warn <= warn_n;
      sec_tick    <= tick;
    end
  end

  // Next-state logic; priority is start > pellet > second-boundary expiry.
  always_comb begin
    state_n       = state;
    saved_mode_n  = saved_mode;
    presc_n       = presc;
    phase_n       = phase;
    saved_phase_n = saved_phase;
    fcnt_n        = fcnt;
    round_n       = round_cnt;
    rev_req       = 1'b0;

    run  = (state != IDLE) && !pause;
    tick = run && (presc == PSW'(TICK_DIV - 1));
    if (run) presc_n = tick ? '0 : presc + PSW'(1);

    if (start) begin
      state_n       = SCATTER;
      saved_mode_n  = IDLE;
      presc_n       = '0;
      phase_n       = '0;
      saved_phase_n = '0;
      fcnt_n        = '0;
      round_n       = '0;
    end else begin
      case (state)
        IDLE: ;
        SCATTER, CHASE: begin
          if (pellet && !pause) begin
            saved_mode_n  = state;
            saved_phase_n = phase;
            state_n       = FRIGHT;
            fcnt_n        = '0;
            presc_n       = '0;
            rev_req       = 1'b1;
          end else if (tick) begin
            if (state == SCATTER) begin
              if (phase == PHW'(SCATTER_S - 1)) begin
                state_n = CHASE;
                phase_n = '0;
                round_n = round_cnt + RW'(1);
                rev_req = 1'b1;
              end else begin
                phase_n = phase + PHW'(1);
              end
            end else if (round_cnt < RW'(ROUNDS)) begin
              if (phase == PHW'(CHASE_S - 1)) begin
                state_n = SCATTER;
                phase_n = '0;
                rev_req = 1'b1;
              end else begin
                phase_n = phase + PHW'(1);
              end
            end
          end
        end
        FRIGHT: begin
          if (pellet && !pause) begin
            fcnt_n  = '0;
            presc_n = '0;
          end else if (tick) begin
            if (fcnt == FW'(FRIGHT_S - 1)) begin
              state_n = saved_mode;
              phase_n = saved_phase;
              fcnt_n  = '0;
            end else begin
              fcnt_n = fcnt + FW'(1);
            end
          end
        end
      endcase
    end

    // A reversal requested right after another one is merged into it.
    reverse_n = rev_req && !reverse;
    warn_n    = (state_n == FRIGHT) && (fcnt_n >= FW'(FRIGHT_S - WARN_S));
  end

  assign mode = state;

endmodule
